// File: rtl/acc_cmd_feeder.sv
// rtl/acc_cmd_feeder.sv - command FIFO and beat sequencer feeding the 8-bit add/sub accumulator
//
// Buffers {op, data, rpt} commands from a valid/ready producer and replays
// each one rpt+1 times as consecutive beats on o_a/o_add_sub. With no work
// it drives a neutral beat (0, add) so the accumulator holds its value.
//
// Ports:
//   i_clk      clock, rising edge
//   ni_rst     asynchronous active-low reset
//   i_valid    producer command valid
//   i_op       0 = add, 1 = subtract
//   i_data     operand
//   i_rpt      extra repetitions (command issues i_rpt+1 beats)
//   o_ready    FIFO can accept a command
//   o_a        operand to the accumulator (registered)
//   o_add_sub  op to the accumulator (registered)
//   o_busy     o_a/o_add_sub carry a live command beat (registered)
//   o_last     final beat of the current command (registered)
//   o_level    FIFO occupancy
//   i_flush    synchronous flush, only when ACC_FEED_FLUSH_EN is defined
//
// Build option: ACC_FEED_FLUSH_EN adds the i_flush port.

module acc_cmd_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int RPT_W  = 4
) (
    input  logic                       i_clk,
    input  logic                       ni_rst,
    input  logic                       i_valid,
    input  logic                       i_op,
    input  logic [DATA_W-1:0]          i_data,
    input  logic [RPT_W-1:0]           i_rpt,
    output logic                       o_ready,
    output logic [DATA_W-1:0]          o_a,
    output logic                       o_add_sub,
    output logic                       o_busy,
    output logic                       o_last,
    output logic [$clog2(DEPTH):0]     o_level
`ifdef ACC_FEED_FLUSH_EN
    ,
    input  logic                       i_flush
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic              mem_op   [DEPTH];
    logic [RPT_W-1:0]  mem_rpt  [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [0:0]       state;
    logic [RPT_W-1:0] rem;

    logic flush;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic can_take;

`ifdef ACC_FEED_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    // Ready comes only from registered occupancy, so a full FIFO refuses a
    // push even when a pop happens on the same edge.
    assign o_ready  = !full && !flush;
    assign push     = i_valid && o_ready;
    // A new command may be taken when idle or when the current beat is the
    // command's last one, which gives back-to-back issue without a bubble.
    assign can_take = (state == IDLE) || (rem == '0);
    assign pop      = !empty && can_take && !flush;
    assign o_level  = level;

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data[wr_ptr] <= i_data;
            mem_op[wr_ptr]   <= i_op;
            mem_rpt[wr_ptr]  <= i_rpt;
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            state     <= IDLE;
            rem       <= '0;
            o_a       <= '0;
            o_add_sub <= 1'b0;
            o_busy    <= 1'b0;
            o_last    <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            state     <= IDLE;
            rem       <= '0;
            o_a       <= '0;
            o_add_sub <= 1'b0;
            o_busy    <= 1'b0;
            o_last    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end

            if (pop) begin
                state     <= ISSUE;
                o_a       <= mem_data[rd_ptr];
                o_add_sub <= mem_op[rd_ptr];
                rem       <= mem_rpt[rd_ptr];
                o_busy    <= 1'b1;
                o_last    <= (mem_rpt[rd_ptr] == '0);
            end else if (state == ISSUE && rem != '0) begin
                // rem counts beats still to come after the one on the outputs.
                rem    <= rem - RPT_W'(1);
                o_last <= (rem == RPT_W'(1));
            end else begin
                state     <= IDLE;
                rem       <= '0;
                o_a       <= '0;
                o_add_sub <= 1'b0;
                o_busy    <= 1'b0;
                o_last    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acc_cmd_feeder.sv
// tb/tb_acc_cmd_feeder.sv - directed and randomized bench for acc_cmd_feeder against a queue model

module tb_acc_cmd_feeder;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int RPT_W  = 4;

    logic              i_clk;
    logic              ni_rst;
    logic              i_valid;
    logic              i_op;
    logic [DATA_W-1:0] i_data;
    logic [RPT_W-1:0]  i_rpt;
    logic              o_ready;
    logic [DATA_W-1:0] o_a;
    logic              o_add_sub;
    logic              o_busy;
    logic              o_last;
    logic [2:0]        o_level;
    logic              flush_in;

    acc_cmd_feeder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RPT_W  (RPT_W)
    ) dut (
        .i_clk     (i_clk),
        .ni_rst    (ni_rst),
        .i_valid   (i_valid),
        .i_op      (i_op),
        .i_data    (i_data),
        .i_rpt     (i_rpt),
        .o_ready   (o_ready),
        .o_a       (o_a),
        .o_add_sub (o_add_sub),
        .o_busy    (o_busy),
        .o_last    (o_last),
        .o_level   (o_level)
`ifdef ACC_FEED_FLUSH_EN
        ,
        .i_flush   (flush_in)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic              op;
        logic [DATA_W-1:0] data;
        logic [RPT_W-1:0]  rpt;
    } cmd_t;

    // Model: commands waiting, the command on the outputs, and how many of
    // its beats (including the one showing) are still to be seen.
    cmd_t q[$];
    cmd_t cur;
    int   cur_left;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic check_all(input string ctx);
        bit busy;
        busy = (cur_left > 0);
        chk({ctx, ":o_a"}, 32'(o_a), busy ? 32'(cur.data) : 32'd0);
        chk({ctx, ":o_add_sub"}, 32'(o_add_sub), busy ? 32'(cur.op) : 32'd0);
        chk({ctx, ":o_busy"}, 32'(o_busy), 32'(busy));
        chk({ctx, ":o_last"}, 32'(o_last), 32'(cur_left == 1));
        chk({ctx, ":o_level"}, 32'(o_level), 32'(q.size()));
        chk({ctx, ":o_ready"}, 32'(o_ready), 32'((q.size() != DEPTH) && !flush_in));
    endtask

    task automatic model_reset();
        q.delete();
        cur_left = 0;
        cur = '{op: 1'b0, data: '0, rpt: '0};
    endtask

    // One clock: decide model push/pop from pre-edge state, advance, check.
    task automatic tick(input string ctx);
        bit   do_push, do_pop, fl, rst;
        cmd_t nc;
        rst     = !ni_rst;
        fl      = flush_in;
        do_push = i_valid && (q.size() != DEPTH) && !fl;
        do_pop  = (q.size() != 0) && (cur_left <= 1) && !fl;
        nc      = '{op: i_op, data: i_data, rpt: i_rpt};
        @(posedge i_clk);
        if (rst || fl) begin
            model_reset();
        end else begin
            if (do_pop) begin
                cur      = q.pop_front();
                cur_left = int'(cur.rpt) + 1;
            end else if (cur_left > 0) begin
                cur_left--;
            end
            if (do_push) q.push_back(nc);
        end
        #1;
        check_all(ctx);
    endtask

    task automatic send(input string ctx, input logic op, input logic [7:0] data, input logic [3:0] rpt);
        bit acc;
        int n;
        i_valid = 1'b1;
        i_op    = op;
        i_data  = data;
        i_rpt   = rpt;
        acc     = 1'b0;
        n       = 0;
        while (!acc && n < 100) begin
            acc = o_ready;
            tick(ctx);
            n++;
        end
        if (!acc) chk({ctx, ":accept_timeout"}, 32'd0, 32'd1);
        i_valid = 1'b0;
    endtask

    task automatic idle(input string ctx, input int n);
        for (int i = 0; i < n; i++) tick(ctx);
    endtask

    initial begin
        ni_rst   = 1'b0;
        i_valid  = 1'b0;
        i_op     = 1'b0;
        i_data   = '0;
        i_rpt    = '0;
        flush_in = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        idle("reset", 2);
        ni_rst = 1'b1;
        idle("post_reset", 2);

        // Reset in the middle of a long command.
        send("t1", 1'b0, 8'h10, 4'd5);
        idle("t1_beats", 2);
        ni_rst = 1'b0;
        #1;
        model_reset();
        check_all("t1_async_reset");
        idle("t1_in_reset", 1);
        ni_rst = 1'b1;
        idle("t1_after", 4);

        // Single-beat command, then idle.
        send("t2", 1'b0, 8'h05, 4'd0);
        chk("t2_level_after_push", 32'(o_level), 32'd1);
        idle("t2_issue", 1);
        chk("t2_beat_a", 32'(o_a), 32'h05);
        chk("t2_beat_last", 32'(o_last), 32'd1);
        idle("t2_idle", 3);

        // Repeated subtract followed back-to-back by an add.
        send("t3a", 1'b1, 8'h03, 4'd2);
        send("t3b", 1'b0, 8'h7F, 4'd0);
        idle("t3", 6);

        // Long command holds the sequencer while the FIFO fills up.
        send("t4_long", 1'b0, 8'h11, 4'd15);
        for (int i = 0; i < 5; i++) send("t4_fill", i[0], 8'(8'hA0 + i), 4'(i));
        idle("t4_drain", 40);

        // Randomized traffic; producer holds a refused command stable.
        for (int i = 0; i < 600; i++) begin
            bit acc;
            if (!i_valid && $urandom_range(0, 2) != 0) begin
                i_valid = 1'b1;
                i_op    = 1'($urandom);
                i_data  = 8'($urandom);
                i_rpt   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            end
            acc = i_valid && o_ready;
            tick("rand");
            if (acc) i_valid = 1'b0;
        end
        i_valid = 1'b0;
        idle("rand_drain", 80);

`ifdef ACC_FEED_FLUSH_EN
        // Flush while issuing with three commands queued; the coincident push is dropped.
        send("t6_long", 1'b1, 8'h20, 4'd10);
        send("t6_q0", 1'b0, 8'h21, 4'd1);
        send("t6_q1", 1'b0, 8'h22, 4'd1);
        send("t6_q2", 1'b0, 8'h23, 4'd1);
        i_valid  = 1'b1;
        i_data   = 8'h99;
        flush_in = 1'b1;
        #1;
        chk("t6_ready_in_flush", 32'(o_ready), 32'd0);
        tick("t6_flush");
        flush_in = 1'b0;
        i_valid  = 1'b0;
        chk("t6_busy", 32'(o_busy), 32'd0);
        chk("t6_level", 32'(o_level), 32'd0);
        idle("t6_after", 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/acc_cmd_feeder.md
Name: acc_cmd_feeder

Overview:
Upstream command stage for the 8-bit self-accumulating add/subtract datapath. Buffers operand commands {op, data, repeat} from a valid/ready producer in a small FIFO. Drives the accumulator's operand and add/sub select one beat per cycle, replaying each command repeat+1 times. When it has no work it drives a neutral beat (data 0, add), so the free-running accumulator holds its value.

Parameters:
DATA_W, 8, operand width; must match the accumulator width.
DEPTH, 4, FIFO entries; power of two, >= 2.
RPT_W, 4, repeat-field width; a command issues i_rpt+1 beats (1..16).

Ports:
i_clk  in  1  clock, rising edge.
ni_rst  in  1  asynchronous active-low reset.
i_valid  in  1  producer command valid.
i_op  in  1  0 = add, 1 = subtract.
i_data  in  DATA_W  operand.
i_rpt  in  RPT_W  extra repetitions.
o_ready  out  1  FIFO can accept a command.
o_a  out  DATA_W  operand to the accumulator.
o_add_sub  out  1  op to the accumulator (0 add, 1 sub).
o_busy  out  1  o_a/o_add_sub carry a live command beat.
o_last  out  1  final beat of the current command.
o_level  out  $clog2(DEPTH)+1  FIFO occupancy.
i_flush  in  1  present only with ACC_FEED_FLUSH_EN.

Behaviour:
- Reset: ni_rst is asynchronous, active-low; clock is i_clk. While reset is low:
  - FIFO empty, o_level = 0, o_ready = 1.
  - FSM in IDLE, repeat counter = 0.
  - o_a = 0, o_add_sub = 0, o_busy = 0, o_last = 0.
- Reset mid-command discards all queued and in-flight beats with no partial output afterwards.
- Handshake and FIFO:
  - o_ready = (o_level != DEPTH), combinational from registered occupancy.
  - Push on rising edge when i_valid && o_ready. Producer must hold i_valid/data stable until accepted.
  - When full, o_ready = 0 even if a pop happens in the same cycle (no push-through when full).
  - Push and pop in the same cycle when not full: o_level unchanged. Read/write pointers wrap modulo DEPTH.
  - No bypass: an entry pushed at edge N can be popped no earlier than edge N+1.
- Output registers: o_a, o_add_sub, o_busy and o_last are all registered.
- FSM has two states, IDLE and ISSUE. Repeat counter `rem` is RPT_W bits.
  - IDLE, FIFO empty: stay in IDLE. Outputs: o_a = 0, o_add_sub = 0, o_busy = 0, o_last = 0.
  - IDLE, FIFO non-empty: pop the head at the edge.
    - Load o_a/o_add_sub from the entry, rem = rpt, o_busy = 1, o_last = (rpt == 0). Go to ISSUE.
  - ISSUE, rem != 0: hold o_a/o_add_sub, rem--, o_last = (rem == 1).
  - ISSUE, rem == 0 (current beat is last), FIFO non-empty: pop the next command at the same edge.
    - Back-to-back with no bubble beat; stay in ISSUE.
  - ISSUE, rem == 0, FIFO empty: go to IDLE. Outputs become 0/add, busy 0, last 0.
- Latency: a command accepted at edge N into an empty, idle block gives its first beat on o_a after edge N+1. It occupies exactly rpt+1 consecutive cycles.
- Steady-state throughput is one beat per cycle while the FIFO is non-empty.
- No arithmetic on data: o_a is a verbatim copy of i_data. Subtract semantics belong to the downstream datapath.
- Idle outputs never glitch to a non-zero operand.

Optional Feature:
Macro ACC_FEED_FLUSH_EN.
- Defined: i_flush port exists and is synchronous. When sampled high at an edge:
  - FIFO is emptied, o_level = 0, FSM goes to IDLE.
  - Outputs go neutral (0/add, busy 0, last 0) after that edge.
  - A simultaneous push is dropped (o_ready is forced 0 while i_flush = 1).
- Not defined: no i_flush port. The FIFO drains only by issuing.

Test Plan:
1. Reset mid-ISSUE (cmd add 0x10 rpt 5, reset at beat 2) -> o_a = 0, o_busy = 0, o_level = 0, o_ready = 1 immediately; nothing issues after release.
2. Single push {add, 0x05, rpt 0} at edge 1 -> o_a = 0x05, o_busy = 1, o_last = 1 for exactly the cycle after edge 2; then 0/add idle.
3. Push {sub, 0x03, rpt 2}, then {add, 0x7F, rpt 0} -> o_a = 03, 03, 03 (sub, last on third beat) then 7F (add, last), with no bubble; then idle.
4. With the FSM held in a rpt 15 command, push 5 commands at DEPTH 4 -> o_ready drops after 4 accepts and o_level = 4. The fifth is accepted only after a pop, and it issues in order.
5. Push and pop in the same cycle at o_level = 2 -> o_level stays 2. Pointer wrap checked over 10 commands; issued data sequence matches the push order.
6. (ACC_FEED_FLUSH_EN) Assert i_flush during ISSUE with 3 queued -> next cycle o_busy = 0, o_a = 0, o_level = 0; a push in the flush cycle is not accepted.
